bsg_fifo_1r1w_small_hardened_multi: RTL and testbench

Bank of fifos_p independent small FIFOs sharing one enqueue port, selected by enq_id_i. Each FIFO exposes its own head (v_o/data_o) and its own dequeue strobe (yumi_i).
Used where several logical queues (e.g. per-destination or per-ID) share a single producer but are drained by independent consumers.
Per-FIFO storage is a small els_p-entry circular buffer.

---
 rtl/bsg_fifo_1r1w_small_hardened_multi.sv | 76 +++++++
 tb/tb_bsg_fifo_1r1w_small_hardened_multi.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_1r1w_small_hardened_multi.sv
// Bank of small circular-buffer FIFOs sharing one enqueue port.
// Each FIFO has its own head outputs and dequeue strobe.
module bsg_fifo_1r1w_small_hardened_multi #(
    parameter int width_p = 32,
    parameter int els_p   = 4,
    parameter int fifos_p = 4,
    localparam int lg_fifos = (fifos_p <= 1) ? 1 : $clog2(fifos_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             v_i,
    input  logic [lg_fifos-1:0]              enq_id_i,
    input  logic [width_p-1:0]               data_i,
    output logic [fifos_p-1:0]               ready_param_o,
    output logic [fifos_p-1:0]               v_o,
    output logic [fifos_p-1:0][width_p-1:0]  data_o,
    input  logic [fifos_p-1:0]               yumi_i
);

    localparam int pw = $clog2(els_p);
    localparam int cw = $clog2(els_p + 1);

    for (genvar g = 0; g < fifos_p; g++) begin : fifo
        logic [pw-1:0]      rptr_q, rptr_d;
        logic [pw-1:0]      wptr_q, wptr_d;
        logic [cw-1:0]      cnt_q, cnt_d;
        logic               full, empty, enq, deq;
        logic [width_p-1:0] mem_q [els_p];

        assign full  = (cnt_q == cw'(els_p));
        assign empty = (cnt_q == '0);
        // Acceptance looks only at registered occupancy, never at yumi_i.
        assign enq = v_i && (enq_id_i == lg_fifos'(g)) && !full;
        assign deq = yumi_i[g] && !empty;

        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            cnt_d  = cnt_q;
            if (enq) begin
                wptr_d = (wptr_q == pw'(els_p - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (deq) begin
                rptr_d = (rptr_q == pw'(els_p - 1)) ? '0 : rptr_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (enq) begin
                mem_q[wptr_q] <= data_i;
            end
        end

        assign ready_param_o[g] = !full;
        assign v_o[g]           = !empty;
        assign data_o[g]        = mem_q[rptr_q];
    end

endmodule

// File: tb/tb_bsg_fifo_1r1w_small_hardened_multi.sv
// Scoreboard bench for the multi-FIFO bank: per-FIFO expected queues
// drive every-cycle checks of v_o, ready_param_o and head data.
module tb_bsg_fifo_1r1w_small_hardened_multi;

    localparam int W  = 32;
    localparam int E  = 4;
    localparam int F  = 4;
    localparam int LF = 2;

    logic                  clk_i = 1'b0;
    logic                  reset_i = 1'b1;
    logic                  v_i = 1'b0;
    logic [LF-1:0]         enq_id_i = '0;
    logic [W-1:0]          data_i = '0;
    logic [F-1:0]          ready_param_o;
    logic [F-1:0]          v_o;
    logic [F-1:0][W-1:0]   data_o;
    logic [F-1:0]          yumi_i = '0;

    int total = 0;
    int bad = 0;
    int seq = 0;
    logic [W-1:0] sb [F][$];

    bsg_fifo_1r1w_small_hardened_multi #(
        .width_p(W), .els_p(E), .fifos_p(F)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .v_i(v_i),
        .enq_id_i(enq_id_i),
        .data_i(data_i),
        .ready_param_o(ready_param_o),
        .v_o(v_o),
        .data_o(data_o),
        .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        logic [F-1:0] ev, er;
        for (int i = 0; i < F; i++) begin
            ev[i] = (sb[i].size() != 0);
            er[i] = (sb[i].size() < E);
        end
        check("v_o", W'(v_o), W'(ev));
        check("ready", W'(ready_param_o), W'(er));
        for (int i = 0; i < F; i++) begin
            if (sb[i].size() != 0) check("head", data_o[i], sb[i][0]);
        end
    endtask

    task automatic step(input logic v, input logic [LF-1:0] id,
                        input logic [W-1:0] d, input logic [F-1:0] y);
        logic acc;
        v_i = v;
        enq_id_i = id;
        data_i = d;
        yumi_i = y;
        check_state();
        acc = v && (sb[id].size() < E);
        for (int i = 0; i < F; i++) begin
            if (y[i] && sb[i].size() != 0)
                check("deq", data_o[i], sb[i].pop_front());
        end
        if (acc) sb[id].push_back(d);
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
        yumi_i = '0;
    endtask

    initial begin
        #1;
        check("rst_v", W'(v_o), 32'h0);
        check("rst_ready", W'(ready_param_o), 32'hf);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_state();

        // FIFO0 single word, then dequeue
        step(1, 0, 32'h0, '0);
        check("f0_v", W'(v_o[0]), 32'h1);
        check("f0_d", data_o[0], 32'h0);
        step(0, 0, 32'h0, 4'b0001);
        check("f0_empty", W'(v_o[0]), 32'h0);

        // FIFO1 enqueue+dequeue with count 1
        step(1, 1, 32'hAAAA_0001, '0);
        step(1, 1, 32'hBBBB_0002, 4'b0010);
        check("f1_v", W'(v_o[1]), 32'h1);
        check("f1_d", data_o[1], 32'hBBBB_0002);
        step(0, 0, 32'h0, 4'b0010);
        check("f1_empty", W'(v_o[1]), 32'h0);

        // enqueue FIFO2 while dequeuing FIFO0
        step(1, 0, 32'h1111_0001, '0);
        step(1, 0, 32'h2222_0002, '0);
        step(1, 2, 32'h3333_0003, 4'b0001);
        check("f0_y", data_o[0], 32'h2222_0002);
        check("f2_z", data_o[2], 32'h3333_0003);
        step(0, 0, 32'h0, 4'b0001);
        check("f0_gone", W'(v_o[0]), 32'h0);
        step(0, 0, 32'h0, 4'b0100);

        // fill FIFO3; fifth enqueue and full+dequeue enqueue refused
        for (int k = 0; k < E; k++) step(1, 3, 32'hC000_0000 + k, '0);
        check("f3_full", W'(ready_param_o[3]), 32'h0);
        step(1, 3, 32'hDEAD_BEEF, '0);
        step(1, 3, 32'hDEAD_0001, 4'b1000);
        check("f3_ready", W'(ready_param_o[3]), 32'h1);
        step(0, 0, 32'h0, 4'b0001);
        for (int k = 0; k < E - 1; k++) step(0, 0, 32'h0, 4'b1000);
        check("f3_drained", W'(v_o[3]), 32'h0);

        // reset mid-operation
        step(1, 1, 32'h5555_0001, '0);
        step(1, 2, 32'h5555_0002, '0);
        #2;
        reset_i = 1'b1;
        #1;
        check("mid_rst_v", W'(v_o), 32'h0);
        check("mid_rst_ready", W'(ready_param_o), 32'hf);
        for (int i = 0; i < F; i++) sb[i].delete();
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // random traffic
        for (int c = 0; c < 20000; c++) begin
            logic          rv;
            logic [LF-1:0] rid;
            logic [F-1:0]  ry;
            rv  = ($urandom_range(0, 99) < 60);
            rid = LF'($urandom_range(0, F - 1));
            ry  = '0;
            if ($urandom_range(0, 99) < 60) ry[$urandom_range(0, F - 1)] = 1'b1;
            seq++;
            step(rv, rid, {8'(rid), 24'(seq)}, ry);
        end

        // drain
        for (int c = 0; c < F * E + 8; c++) begin
            logic [F-1:0] ry;
            ry = '0;
            for (int i = F - 1; i >= 0; i--) if (sb[i].size() != 0) ry = F'(1) << i;
            step(0, 0, 32'h0, ry);
        end
        check_state();
        check("end_empty", W'(v_o), 32'h0);
        check("end_ready", W'(ready_param_o), 32'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
